// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: EX/MEM shadow pipeline, registered per-source forwarding selects,
// load-use stall and memory-wait freeze. Define FWD_PERF_CNT_EN to add stall/freeze cycle counters.
module fwd_hazard_unit #(
  parameter int unsigned AW   = 4,
  parameter int unsigned NSRC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [AW-1:0]        id_dst,
  input  logic                 id_regwrite,
  input  logic                 id_is_load,
  input  logic                 mem_ready,
  input  logic                 flush,
  output logic [2*NSRC-1:0]    ex_fwd_sel,
  output logic                 stall,
  output logic                 freeze
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [15:0]          stall_cycles,
  output logic [15:0]          freeze_cycles
`endif
);

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dst;
    logic          regwrite;
    logic          is_load;
  } shadow_t;

  // The WB entry is never consulted: a WB-stage writer is visible through the
  // write-first register file, so only EX and MEM entries are kept.
  shadow_t ex_q;
  shadow_t mem_q;

  logic              ex_wr;
  logic              mem_wr;
  logic              src_hits_ex;
  logic              load_use;
  logic [2*NSRC-1:0] sel_next;

  assign ex_wr  = ex_q.valid  & ex_q.regwrite  & (ex_q.dst  != '0);
  assign mem_wr = mem_q.valid & mem_q.regwrite & (mem_q.dst != '0);

  always_comb begin
    sel_next    = '0;
    src_hits_ex = 1'b0;
    if (id_valid) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        if (id_src[k*AW +: AW] != '0) begin
          if (ex_wr && (ex_q.dst == id_src[k*AW +: AW])) begin
            sel_next[2*k +: 2] = SEL_MEM;
            src_hits_ex        = 1'b1;
          end else if (mem_wr && (mem_q.dst == id_src[k*AW +: AW])) begin
            sel_next[2*k +: 2] = SEL_WB;
          end
        end
      end
    end
  end

  assign load_use = id_valid & ex_wr & ex_q.is_load & src_hits_ex;
  assign freeze   = ~reset & mem_q.valid & mem_q.is_load & ~mem_ready;
  assign stall    = ~reset & ~freeze & ~flush & load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      mem_q      <= '0;
      ex_fwd_sel <= '0;
    end else if (!freeze) begin
      mem_q <= ex_q;
      if (flush || stall) begin
        ex_q       <= '0;
        ex_fwd_sel <= '0;
      end else begin
        ex_q       <= '{valid: id_valid, dst: id_dst, regwrite: id_regwrite, is_load: id_is_load};
        ex_fwd_sel <= sel_next;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 16'd1;
      if (freeze && (freeze_cycles != '1))
        freeze_cycles <= freeze_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit: forwarding, load-use, freeze, flush, reset.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [7:0] id_src;
  logic [3:0] id_dst;
  logic       id_regwrite;
  logic       id_is_load;
  logic       mem_ready;
  logic       flush;
  logic [3:0] ex_fwd_sel;
  logic       stall;
  logic       freeze;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] freeze_cycles;
`endif

  int tests = 0;
  int fails = 0;

  fwd_hazard_unit #(.AW(4), .NSRC(2)) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_src(id_src),
    .id_dst(id_dst),
    .id_regwrite(id_regwrite),
    .id_is_load(id_is_load),
    .mem_ready(mem_ready),
    .flush(flush),
    .ex_fwd_sel(ex_fwd_sel),
    .stall(stall),
    .freeze(freeze)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .freeze_cycles(freeze_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ID instruction: valid, src1, src0, dst, regwrite, is_load
  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s0,
                        input logic [3:0] d, input logic rw, input logic ld);
    id_valid    = v;
    id_src      = {s1, s0};
    id_dst      = d;
    id_regwrite = rw;
    id_is_load  = ld;
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; flush = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_sel", ex_fwd_sel, 4'b0000);
    chk("reset_stall", stall, 1'b0);
    chk("reset_freeze", freeze, 1'b0);
    reset = 1'b0;

    // A: write r3; B reads r3 on src0 -> MEM forward
    set_id(1'b1, 4'd2, 4'd1, 4'd3, 1'b1, 1'b0); tick();
    set_id(1'b1, 4'd0, 4'd3, 4'd6, 1'b1, 1'b0);
    chk("alu_use_nostall", stall, 1'b0);
    tick();
    chk("fwd_mem_src0", ex_fwd_sel, 4'b0001);

    // C writes r3, D independent, E reads r3 on src1 -> WB forward
    set_id(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0); tick();
    chk("c_sel", ex_fwd_sel, 4'b0000);
    set_id(1'b1, 4'd9, 4'd8, 4'd7, 1'b1, 1'b0); tick();
    chk("indep_sel", ex_fwd_sel, 4'b0000);
    set_id(1'b1, 4'd3, 4'd0, 4'd10, 1'b1, 1'b0); tick();
    chk("fwd_wb_src1", ex_fwd_sel, 4'b1000);

    // F, G both write r5; H reads r5 on both -> youngest (MEM) wins
    set_id(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 4'd5, 4'd5, 4'd11, 1'b1, 1'b0); tick();
    chk("youngest_wins", ex_fwd_sel, 4'b0101);
    // I writes r0; J reads r0 and r5 (no live writer of r5 any more)
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0); tick();
    set_id(1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0); tick();
    chk("r0_never_fwd", ex_fwd_sel, 4'b0000);

    // K loads r4; L reads r4 -> one stall, bubble, then WB forward
    set_id(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1); tick();
    set_id(1'b1, 4'd1, 4'd4, 4'd12, 1'b1, 1'b0);
    chk("load_use_stall", stall, 1'b1);
    tick();
    chk("bubble_sel", ex_fwd_sel, 4'b0000);
    chk("stall_one_cycle", stall, 1'b0);
    chk("no_freeze_ready", freeze, 1'b0);
    tick();
    chk("after_stall_sel", ex_fwd_sel, 4'b0010);

    // W writes r14; M loads r2 reading r14; N reads r14 on src1
    set_id(1'b1, 4'd0, 4'd0, 4'd14, 1'b1, 1'b0); tick();
    chk("w_sel", ex_fwd_sel, 4'b0000);
    set_id(1'b1, 4'd0, 4'd14, 4'd2, 1'b1, 1'b1); tick();
    chk("m_sel", ex_fwd_sel, 4'b0001);
    set_id(1'b1, 4'd14, 4'd0, 4'd13, 1'b1, 1'b0);
    chk("n_nostall", stall, 1'b0);
    tick();
    chk("n_sel", ex_fwd_sel, 4'b1000);

    // Load M in MEM, mem_ready low for 3 cycles, flush asserted and ignored
    mem_ready = 1'b0; flush = 1'b1;
    set_id(1'b1, 4'd0, 4'd13, 4'd15, 1'b1, 1'b0);
    chk("freeze_c1", freeze, 1'b1);
    chk("freeze_nostall", stall, 1'b0);
    tick();
    chk("freeze_c2", freeze, 1'b1);
    chk("freeze_hold_c2", ex_fwd_sel, 4'b1000);
    tick();
    chk("freeze_c3", freeze, 1'b1);
    chk("freeze_hold_c3", ex_fwd_sel, 4'b1000);
    tick();
    chk("freeze_hold_c4", ex_fwd_sel, 4'b1000);
    mem_ready = 1'b1; flush = 1'b0;
    #1;
    chk("freeze_released", freeze, 1'b0);
    tick();
    chk("p_after_freeze", ex_fwd_sel, 4'b0001);
`ifdef FWD_PERF_CNT_EN
    chk("freeze_cnt", freeze_cycles, 16'd3);
    chk("stall_cnt", stall_cycles, 16'd1);
`endif

    // Q would forward from P, but flush squashes it
    flush = 1'b1;
    set_id(1'b1, 4'd0, 4'd15, 4'd0, 1'b0, 1'b0);
    chk("flush_nostall", stall, 1'b0);
    tick();
    chk("flush_sel", ex_fwd_sel, 4'b0000);
    flush = 1'b0;

    // T writes r9, R loads r1, S reads r9 -> WB forward; then freeze and reset
    set_id(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0); tick();
    set_id(1'b1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1); tick();
    set_id(1'b1, 4'd0, 4'd9, 4'd8, 1'b1, 1'b0); tick();
    chk("s_sel", ex_fwd_sel, 4'b0010);
    mem_ready = 1'b0;
    set_id(1'b1, 4'd0, 4'd8, 4'd7, 1'b1, 1'b0);
    chk("freeze_pre_reset", freeze, 1'b1);
    reset = 1'b1;
    #1;
    chk("freeze_in_reset", freeze, 1'b0);
    chk("stall_in_reset", stall, 1'b0);
    tick();
    chk("sel_after_reset", ex_fwd_sel, 4'b0000);
    reset = 1'b0;
    #1;
    chk("no_pending_load", freeze, 1'b0);
    chk("stall_after_reset", stall, 1'b0);
`ifdef FWD_PERF_CNT_EN
    chk("freeze_cnt_clr", freeze_cycles, 16'd0);
    chk("stall_cnt_clr", stall_cycles, 16'd0);
`endif
    tick();
    chk("sel_first_after_reset", ex_fwd_sel, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
